// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int unsigned OSR   = 16;
    localparam int unsigned SMP_A = 7;
    localparam int unsigned SMP_B = 8;
    localparam int unsigned SMP_C = 9;

    function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned osr);
        return clk_hz / (baud * osr);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clock pulse every TICK_DIV clocks, restartable.
module uart_os_tick #(
    parameter int unsigned TICK_DIV = 27
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OSR);

    uart_state_e state_q, state_d;
    logic [1:0]  sync_q;
    logic        rx_prev_q;
    logic [3:0]  ti_q, ti_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        va_q, va_d, vb_q, vb_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    logic rx_s, fall, tick, clear, maj, commit, bit_end;

    assign rx_s    = sync_q[1];
    assign fall    = rx_prev_q & ~rx_s;
    assign clear   = (state_q == IDLE) && fall;
    assign maj     = (va_q & vb_q) | (va_q & rx_s) | (vb_q & rx_s);
    assign commit  = tick && (ti_q == 4'(SMP_C));
    assign bit_end = tick && (ti_q == 4'(OSR - 1));

    uart_os_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .nRst  (nRst),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        ti_d    = ti_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        va_d    = va_q;
        vb_d    = vb_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (tick && (state_q != IDLE) && (state_q != BREAK)) begin
            ti_d = ti_q + 4'd1;
            if (ti_q == 4'(SMP_A)) va_d = rx_s;
            if (ti_q == 4'(SMP_B)) vb_d = rx_s;
        end

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    ti_d    = '0;
                end
            end
            START: begin
                if (commit && maj) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (commit) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            // Leave at the stop-bit centre so a start bit right behind it is caught.
            STOP: begin
                if (commit) begin
                    if (maj) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            ti_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            va_q      <= 1'b1;
            vb_q      <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            ti_q      <= ti_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            va_q      <= va_d;
            vb_q      <= vb_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
